bin2bcd_display_src: RTL and testbench



---
 rtl/bin2bcd_display_src_pkg.sv | 23 ++
 rtl/bcd_digit_adjust.sv | 14 +
 rtl/bin2bcd_display_src.sv | 152 +++++++++++++++
 tb/tb_bin2bcd_display_src.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_display_src_pkg.sv
// Shared constants and types for the binary-to-BCD display source.
// Holds the digit count, the largest displayable value, the saturation
// pattern, the reset enable masks and the controller state encoding.
package bin2bcd_display_src_pkg;

    localparam int unsigned BCD_DIGITS = 6;
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned BCD_MAX    = 999999;

    // Shown when the input cannot be represented in six digits.
    localparam logic [23:0] BCD_OVF = 24'h999999;

    // Reset enable: a single "0" when blanking, otherwise every digit lit.
    localparam logic [5:0] ENABLE_RST_LZ = 6'b000001;
    localparam logic [5:0] ENABLE_ALL    = 6'b111111;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StFinish
    } state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction cell for one BCD digit.
// Ports:
//   digit    - current 4-bit accumulator nibble
//   adjusted - nibble plus 3 when it is 5 or more, otherwise unchanged
module bcd_digit_adjust (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end

endmodule

// File: rtl/bin2bcd_display_src.sv
// Iterative binary-to-BCD converter feeding the six-digit display.
// A start in IDLE captures bin_in and runs BIN_W shift-add-3 iterations;
// the display outputs are registered only on completion, so intermediate
// accumulator values are never visible. Inputs above 999999 saturate.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   start      - conversion request, honoured only while idle
//   bin_in     - unsigned value, captured when start is accepted
//   busy       - conversion in progress (through the done cycle)
//   done       - one-cycle pulse when the outputs below were just updated
//   number_BCD - six BCD digits, digit 0 in [3:0]
//   enable     - per-digit enable, leading zeros blanked when BLANK_LZ
//   twinkle    - per-digit blink request, all set on overflow
//   overflow   - last conversion saturated
module bin2bcd_display_src
    import bin2bcd_display_src_pkg::*;
#(
    parameter int unsigned BIN_W    = 20,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [23:0]      number_BCD,
    output logic [5:0]       enable,
    output logic [5:0]       twinkle,
    output logic             overflow
);

    localparam int unsigned CNT_W      = $clog2(BIN_W + 1);
    localparam logic [5:0]  ENABLE_RST = BLANK_LZ ? ENABLE_RST_LZ : ENABLE_ALL;

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   acc_q;
    logic [BIN_W-1:0]   sh_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept;
    logic               in_range;
    logic               last_iter;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W+BIN_W-1:0] shifted;
    logic [BCD_W-1:0]   acc_next;
    logic [5:0]         lz_mask;

    assign accept    = (state_q == StIdle) && start;
    assign in_range  = 64'(bin_in) <= 64'(BCD_MAX);
    assign last_iter = (state_q == StShift) && (cnt_q == CNT_W'(1));

    // Shift datapath: correct every nibble, then shift {acc, bin} left.
    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (acc_q[4*i +: 4]),
            .adjusted (adj[4*i +: 4])
        );
    end

    assign shifted  = {adj, sh_q} << 1;
    assign acc_next = shifted[BIN_W +: BCD_W];

    // Digit i is lit if it or any more significant digit is nonzero;
    // digit 0 is always lit so zero shows as a single "0".
    always_comb begin
        logic any_nz;
        any_nz  = 1'b0;
        lz_mask = '0;
        for (int i = int'(BCD_DIGITS) - 1; i >= 0; i--) begin
            any_nz     = any_nz | (acc_next[4*i +: 4] != 4'd0);
            lz_mask[i] = any_nz;
        end
        lz_mask[0] = 1'b1;
        if (!BLANK_LZ) begin
            lz_mask = ENABLE_ALL;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = in_range ? StShift : StFinish;
                end
            end
            StShift: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Handshake outputs.
    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StFinish);
    end

    // Conversion datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            acc_q <= '0;
            sh_q  <= bin_in;
            cnt_q <= CNT_W'(BIN_W);
        end else if (state_q == StShift) begin
            acc_q <= acc_next;
            sh_q  <= shifted[BIN_W-1:0];
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Display registers load on the edge that enters FINISH, so they are
    // already valid in the cycle done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            number_BCD <= 24'h000000;
            enable     <= ENABLE_RST;
            twinkle    <= 6'b000000;
            overflow   <= 1'b0;
        end else if (accept && !in_range) begin
            number_BCD <= BCD_OVF;
            enable     <= ENABLE_ALL;
            twinkle    <= 6'b111111;
            overflow   <= 1'b1;
        end else if (last_iter) begin
            number_BCD <= acc_next;
            enable     <= lz_mask;
            twinkle    <= 6'b000000;
            overflow   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bin2bcd_display_src.sv
// Scoreboard bench: the driver predicts each accepted conversion with a
// decimal-arithmetic model and queues it; a monitor pops on done and also
// checks busy and output stability every cycle. Two instances run in
// lockstep, one with leading-zero blanking and one without.
module tb_bin2bcd_display_src;

    localparam int BIN_W = 20;

    typedef struct {
        logic [23:0] bcd;
        logic [5:0]  en_lz;
        logic [5:0]  tw;
        logic        ovf;
        int          due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [BIN_W-1:0] bin_in = '0;

    logic        busy0, done0, ovf0, busy1, done1, ovf1;
    logic [23:0] bcd0, bcd1;
    logic [5:0]  en0, tw0, en1, tw1;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   busy_lo = 1;
    int   busy_hi = 0;
    int   idle_from = 1;
    exp_t q[$];
    exp_t shown;

    bin2bcd_display_src #(.BIN_W(BIN_W), .BLANK_LZ(1'b1)) dut_lz (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bin_in     (bin_in),
        .busy       (busy0),
        .done       (done0),
        .number_BCD (bcd0),
        .enable     (en0),
        .twinkle    (tw0),
        .overflow   (ovf0)
    );

    bin2bcd_display_src #(.BIN_W(BIN_W), .BLANK_LZ(1'b0)) dut_all (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bin_in     (bin_in),
        .busy       (busy1),
        .done       (done1),
        .number_BCD (bcd1),
        .enable     (en1),
        .twinkle    (tw1),
        .overflow   (ovf1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t reset_exp();
        exp_t e;
        e.bcd   = 24'h000000;
        e.en_lz = 6'b000001;
        e.tw    = 6'b000000;
        e.ovf   = 1'b0;
        e.due   = 0;
        return e;
    endfunction

    // Decimal reference: digits by repeated division, enable up to the
    // most significant nonzero digit.
    function automatic exp_t model(input int unsigned v);
        exp_t        e;
        int unsigned t;
        int unsigned d;
        int          top;
        e.due = 0;
        if (v > 999999) begin
            e.bcd   = 24'h999999;
            e.en_lz = 6'b111111;
            e.tw    = 6'b111111;
            e.ovf   = 1'b1;
        end else begin
            t   = v;
            top = 0;
            e.bcd = '0;
            for (int i = 0; i < 6; i++) begin
                d = t % 10;
                e.bcd[4*i +: 4] = 4'(d);
                if (d != 0) top = i;
                t = t / 10;
            end
            e.en_lz = 6'((1 << (top + 1)) - 1);
            e.tw    = 6'b000000;
            e.ovf   = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle; the model decides acceptance for the coming edge.
    task automatic step(input logic s, input int unsigned b, input logic r);
        exp_t e;
        int   edge_n;
        @(negedge clk);
        start  = s;
        bin_in = BIN_W'(b);
        rst    = r;
        edge_n = cyc + 1;
        if (r) begin
            q.delete();
            busy_lo   = 1;
            busy_hi   = 0;
            idle_from = edge_n + 1;
            shown     = reset_exp();
        end else if (s && edge_n >= idle_from) begin
            e         = model(b);
            e.due     = e.ovf ? edge_n : edge_n + BIN_W;
            busy_lo   = edge_n;
            busy_hi   = e.due;
            idle_from = e.due + 2;
            q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && (cyc + 1) < idle_from; k++) begin
            step(1'b0, $urandom, 1'b0);
        end
    endtask

    // Monitor, sampling 1 time unit after each active edge.
    initial begin
        exp_t e;
        shown = reset_exp();
        forever begin
            @(posedge clk);
            #1;
            if (done0 === 1'b1 || (q.size() > 0 && q[0].due == cyc)) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'(done0), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("done_lz", 32'(done0), 32'd1);
                    chk("done_all", 32'(done1), 32'd1);
                    chk("done_latency", cyc, e.due);
                    shown = e;
                end
            end else begin
                chk("done_lz_idle", 32'(done0), 32'd0);
                chk("done_all_idle", 32'(done1), 32'd0);
            end
            chk("bcd_lz", 32'(bcd0), 32'(shown.bcd));
            chk("enable_lz", 32'(en0), 32'(shown.en_lz));
            chk("twinkle_lz", 32'(tw0), 32'(shown.tw));
            chk("overflow_lz", 32'(ovf0), 32'(shown.ovf));
            chk("bcd_all", 32'(bcd1), 32'(shown.bcd));
            chk("enable_all", 32'(en1), 32'h3f);
            chk("twinkle_all", 32'(tw1), 32'(shown.tw));
            chk("overflow_all", 32'(ovf1), 32'(shown.ovf));
            chk("busy_lz", 32'(busy0), 32'(cyc >= busy_lo && cyc <= busy_hi));
            chk("busy_all", 32'(busy1), 32'(cyc >= busy_lo && cyc <= busy_hi));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned dir [6];
        dir = '{0, 123456, 907, 999999, 1000000, 1048575};

        repeat (3) step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);

        foreach (dir[i]) begin
            step(1'b1, dir[i], 1'b0);
            wait_idle();
        end

        // Start held high with a changing input: only idle samples convert.
        repeat (70) step(1'b1, $urandom_range(0, 999999), 1'b0);
        wait_idle();

        // Reset ten cycles into a conversion, with ignored starts while busy.
        step(1'b1, 54321, 1'b0);
        repeat (9) step(1'b1, 777, 1'b0);
        step(1'b0, 0, 1'b1);
        step(1'b1, 54321, 1'b0);
        wait_idle();

        step(1'b1, 42, 1'b0);
        wait_idle();

        // Random starts, some landing while busy, some overflowing.
        repeat (400) begin
            if ($urandom_range(0, 3) == 0)
                step(1'b1, $urandom_range(0, 1048575), 1'b0);
            else if ($urandom_range(0, 5) == 0)
                step(1'b1, $urandom_range(0, 999), 1'b0);
            else
                step(1'b0, $urandom, 1'b0);
        end

        for (int k = 0; k < 60 && q.size() > 0; k++) step(1'b0, 0, 1'b0);
        chk("drain_queue", 32'(q.size()), 32'd0);
        repeat (3) step(1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
